// File: rtl/icache_line_fill_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the instruction-cache line filler.
//   LINE_W / BEAT_W / NUM_BEATS : line and burst-beat geometry
//   ADDR_W / OFFSET_BITS        : byte address width and in-line offset width
//   fill_state_e                : filler FSM states
//   line_t                      : one assembled cache line
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int NUM_BEATS   = LINE_W / BEAT_W;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_IDX_W  = $clog2(NUM_BEATS);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT      = BEAT_IDX_W'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0]     LINE_ADDR_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } fill_state_e;

    typedef logic [LINE_W-1:0] line_t;

    // Clears the byte offset so the burst always starts on a line boundary.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/icache_line_fill_beat_shifter.sv
// -----------------------------------------------------------------------------
// fill_beat_shifter
// Beat index counter plus line assembly register for the icache line filler.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : restart the beat index at 0 (line contents are kept)
//   beat_valid_i  : write beat_data_i into the current beat slot and advance
//   beat_data_i   : one memory beat
//   beat_idx_o    : index of the slot the next beat will land in
//   line_o        : assembled line
// -----------------------------------------------------------------------------
module fill_beat_shifter
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_W-1:0]     beat_data_i,
    output logic [BEAT_IDX_W-1:0] beat_idx_o,
    output line_t                 line_o
);

    logic [BEAT_IDX_W-1:0] beat_idx_d, beat_idx_q;
    line_t                 line_d, line_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the block leaves it unassigned (which would infer a latch).
        beat_idx_d = beat_idx_q;
        line_d     = line_q;
        if (clear_i) begin
            beat_idx_d = '0;
        end else if (beat_valid_i) begin
            // Index is exactly BEAT_IDX_W bits, so it wraps after the last beat.
            beat_idx_d                        = beat_idx_q + BEAT_IDX_W'(1);
            line_d[BEAT_W*beat_idx_q +: BEAT_W] = beat_data_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            beat_idx_q <= '0;
            // NOTE: the line register is reset (it is flops, not a RAM) so a partial line never survives a reset.
            line_q     <= '0;
        end else begin
            beat_idx_q <= beat_idx_d;
            line_q     <= line_d;
        end
    end

    assign beat_idx_o = beat_idx_q;
    assign line_o     = line_q;

endmodule

// File: rtl/icache_line_fill.sv
// -----------------------------------------------------------------------------
// icache_line_fill
// Memory-side line filler: takes a line request from the icache, issues a
// 4-beat burst read, assembles the beats and returns the line with a
// single-cycle response. All outputs are registered.
//   clk, rst       : clock, synchronous active-high reset
//   line_read_i    : icache line request (held until line_resp_o)
//   line_addr_i    : byte address of the requested line (any offset)
//   line_resp_o    : one-cycle pulse, line_data_o valid
//   line_data_o    : assembled line (holds until the next fill's first beat)
//   burst_read_o   : burst read request to memory, high for the whole burst
//   burst_addr_o   : line-aligned burst address
//   burst_data_i   : beat data from memory
//   burst_resp_i   : beat valid, one beat per asserted cycle
// Optional (macro ICACHE_FILL_PERF_EN):
//   fill_count_o   : completed fills, saturating
//   stall_count_o  : burst cycles without a beat, saturating
// -----------------------------------------------------------------------------
module icache_line_fill
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read_i,
    input  logic [ADDR_W-1:0] line_addr_i,
    output logic              line_resp_o,
    output line_t             line_data_o,
    output logic              burst_read_o,
    output logic [ADDR_W-1:0] burst_addr_o,
    input  logic [BEAT_W-1:0] burst_data_i,
    input  logic              burst_resp_i
`ifdef ICACHE_FILL_PERF_EN
    ,
    output logic [31:0]       fill_count_o,
    output logic [31:0]       stall_count_o
`endif
);

    fill_state_e           state_d, state_q;
    logic                  line_resp_d, line_resp_q;
    logic                  burst_read_d, burst_read_q;
    logic [ADDR_W-1:0]     burst_addr_d, burst_addr_q;
    logic                  beat_clear;
    logic                  beat_capture;
    logic [BEAT_IDX_W-1:0] beat_idx;

    fill_beat_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (beat_clear),
        .beat_valid_i (beat_capture),
        .beat_data_i  (burst_data_i),
        .beat_idx_o   (beat_idx),
        .line_o       (line_data_o)
    );

    always_comb begin
        state_d      = state_q;
        line_resp_d  = 1'b0;
        burst_read_d = burst_read_q;
        burst_addr_d = burst_addr_q;
        beat_clear   = 1'b0;
        beat_capture = 1'b0;
        case (state_q)
            // Beats arriving while idle are dropped: beat_capture stays low.
            IDLE: begin
                burst_read_d = 1'b0;
                if (line_read_i) begin
                    state_d      = BURST;
                    burst_read_d = 1'b1;
                    burst_addr_d = line_align(line_addr_i);
                    beat_clear   = 1'b1;
                end
            end
            BURST: begin
                burst_read_d = 1'b1;
                if (burst_resp_i) begin
                    beat_capture = 1'b1;
                    if (beat_idx == LAST_BEAT) begin
                        state_d      = DONE;
                        burst_read_d = 1'b0;
                        line_resp_d  = 1'b1;
                    end
                end
            end
            // line_read_i is still high here; it is deliberately not sampled.
            DONE: begin
                state_d      = IDLE;
                burst_read_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                burst_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_resp_q  <= 1'b0;
            burst_read_q <= 1'b0;
            burst_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            line_resp_q  <= line_resp_d;
            burst_read_q <= burst_read_d;
            burst_addr_q <= burst_addr_d;
        end
    end

    assign line_resp_o  = line_resp_q;
    assign burst_read_o = burst_read_q;
    assign burst_addr_o = burst_addr_q;

`ifdef ICACHE_FILL_PERF_EN
    logic [31:0] fill_count_d,  fill_count_q;
    logic [31:0] stall_count_d, stall_count_q;

    // fill_count moves together with the response pulse it counts.
    always_comb begin
        fill_count_d  = fill_count_q;
        stall_count_d = stall_count_q;
        if (line_resp_d && (fill_count_q != '1)) begin
            fill_count_d = fill_count_q + 32'd1;
        end
        if ((state_q == BURST) && !burst_resp_i && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            fill_count_q  <= fill_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fill_count_o  = fill_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// -----------------------------------------------------------------------------
// tb_icache_line_fill
// Self-checking bench for icache_line_fill. A table of fill vectors drives the
// main function; hand-written sequences cover back-to-back fills, beats in
// DONE/IDLE, and reset mid-burst. Expected lines go into a scoreboard queue
// when a fill is accepted and are popped when line_resp_o fires.
// Optional counters are exercised when ICACHE_FILL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_icache_line_fill;
    import icache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_read_i;
    logic [ADDR_W-1:0] line_addr_i;
    logic              line_resp_o;
    line_t             line_data_o;
    logic              burst_read_o;
    logic [ADDR_W-1:0] burst_addr_o;
    logic [BEAT_W-1:0] burst_data_i;
    logic              burst_resp_i;
`ifdef ICACHE_FILL_PERF_EN
    logic [31:0]       fill_count_o;
    logic [31:0]       stall_count_o;
`endif

    icache_line_fill dut (
        .clk          (clk),
        .rst          (rst),
        .line_read_i  (line_read_i),
        .line_addr_i  (line_addr_i),
        .line_resp_o  (line_resp_o),
        .line_data_o  (line_data_o),
        .burst_read_o (burst_read_o),
        .burst_addr_o (burst_addr_o),
        .burst_data_i (burst_data_i),
        .burst_resp_i (burst_resp_i)
`ifdef ICACHE_FILL_PERF_EN
        ,
        .fill_count_o  (fill_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] exp_addr;
        logic [BEAT_W-1:0] beat [4];
        int                gap  [4];   // idle cycles before each beat
        bit                chaos;      // wiggle line_addr_i/line_read_i mid-burst
    } fill_vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        line_t             line;
    } sb_item_t;

    sb_item_t  sb_q[$];
    fill_vec_t vecs[5];
    line_t     model_line;
    int        checks       = 0;
    int        errors       = 0;
    int        resp_seen    = 0;
    int        fills_pushed = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fill_vec_t mk(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_addr,
                                     input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                                     input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3,
                                     input int g0, input int g1, input int g2, input int g3,
                                     input bit chaos);
        fill_vec_t v;
        v.addr     = addr;
        v.exp_addr = exp_addr;
        v.beat[0]  = b0;  v.beat[1] = b1;  v.beat[2] = b2;  v.beat[3] = b3;
        v.gap[0]   = g0;  v.gap[1]  = g1;  v.gap[2]  = g2;  v.gap[3]  = g3;
        v.chaos    = chaos;
        return v;
    endfunction

    // Scoreboard consumer: every response must match the oldest accepted fill.
    always @(negedge clk) begin
        sb_item_t it;
        if (!rst && line_resp_o) begin
            resp_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got line_resp_o=1 expected no response (t=%0t)", $time);
            end else begin
                it = sb_q.pop_front();
                check("resp_line", line_data_o, it.line);
                check("resp_burst_addr", burst_addr_o, it.addr);
                check("resp_burst_read_low", burst_read_o, 1'b0);
            end
        end
    end

    // Drives one fill; returns in the DONE cycle with line_read_i still high.
    // exp_wait > 0 checks how many edges it took for burst_read_o to rise.
    task automatic run_fill(input fill_vec_t v, input int exp_wait);
        int       waited;
        bit       ok;
        sb_item_t it;
        burst_resp_i = 1'b0;
        line_read_i  = 1'b1;
        line_addr_i  = v.addr;
        waited = 0;
        ok     = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (burst_read_o === 1'b1) begin
                waited = i;
                ok     = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1'b1);
        if (!ok) return;
        if (exp_wait > 0) check("accept_latency", waited, exp_wait);
        check("burst_addr", burst_addr_o, v.exp_addr);
        it.addr = v.exp_addr;
        it.line = {v.beat[3], v.beat[2], v.beat[1], v.beat[0]};
        sb_q.push_back(it);
        fills_pushed++;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < v.gap[k]; g++) begin
                burst_resp_i = 1'b0;
                burst_data_i = {$urandom(), $urandom()};
                if (v.chaos) begin
                    line_addr_i = 32'hDEAD_BEEF;
                    line_read_i = g[0];
                end
                tick();
                check("gap_burst_read_held", burst_read_o, 1'b1);
                check("gap_line_hold", line_data_o, model_line);
                check("gap_addr_hold", burst_addr_o, v.exp_addr);
            end
            burst_resp_i = 1'b1;
            burst_data_i = v.beat[k];
            if (v.chaos) line_addr_i = 32'hDEAD_BEEF;
            tick();
            model_line[BEAT_W*k +: BEAT_W] = v.beat[k];
            check("beat_capture", line_data_o, model_line);
            if (k < 3) begin
                check("beat_burst_read", burst_read_o, 1'b1);
                check("beat_no_resp", line_resp_o, 1'b0);
            end else begin
                check("resp_latency", line_resp_o, 1'b1);
                check("done_burst_read_low", burst_read_o, 1'b0);
            end
        end
        burst_resp_i = 1'b0;
        line_read_i  = 1'b1;
        line_addr_i  = v.addr;
    endtask

    task automatic idle_after_fill();
        line_read_i  = 1'b0;
        burst_resp_i = 1'b0;
        tick();
        check("resp_one_cycle", line_resp_o, 1'b0);
        check("idle_line_hold", line_data_o, model_line);
        check("idle_burst_read", burst_read_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(32'h0000_1234, 32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 0, 0, 1'b0);
        vecs[1] = mk(32'h0000_1234, 32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 3, 0, 1'b0);
        vecs[2] = mk(32'h0000_1234, 32'h0000_1220, 64'hA5A5_0000_1111_0001, 64'hA5A5_0000_2222_0002,
                     64'hA5A5_0000_3333_0003, 64'hA5A5_0000_4444_0004, 1, 0, 2, 1, 1'b1);
        vecs[3] = mk(32'hFFFF_FFFF, 32'hFFFF_FFE0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 2, 0, 0, 1, 1'b0);
        vecs[4] = mk(32'h0000_001F, 32'h0000_0000, 64'hCAFE_F00D_0000_0000, 64'h0000_0000_CAFE_F00D,
                     64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080, 0, 1, 0, 0, 1'b0);

        rst          = 1'b1;
        line_read_i  = 1'b0;
        line_addr_i  = '0;
        burst_data_i = '0;
        burst_resp_i = 1'b0;
        model_line   = '0;
        repeat (3) tick();
        check("reset_line_resp", line_resp_o, 1'b0);
        check("reset_line_data", line_data_o, '0);
        check("reset_burst_read", burst_read_o, 1'b0);
        check("reset_burst_addr", burst_addr_o, '0);
        rst = 1'b0;
        tick();

        // Table-driven fills from IDLE.
        foreach (vecs[i]) begin
            run_fill(vecs[i], 1);
            idle_after_fill();
        end

        // Back-to-back: request held through DONE is taken two edges later.
        run_fill(vecs[0], 1);
        run_fill(vecs[3], 2);
        idle_after_fill();

        // Beats in DONE and in the following IDLE cycle must not touch the line.
        run_fill(vecs[1], 1);
        line_read_i  = 1'b0;
        burst_resp_i = 1'b1;
        burst_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        check("done_beat_ignored", line_data_o, model_line);
        tick();
        check("idle_beat_ignored", line_data_o, model_line);
        check("idle_beat_no_burst", burst_read_o, 1'b0);
        burst_resp_i = 1'b0;
        tick();

        // Reset after two beats: no response, line cleared, stray beats dropped.
        line_read_i = 1'b1;
        line_addr_i = 32'h0000_1234;
        tick();
        check("abort_accept", burst_read_o, 1'b1);
        burst_resp_i = 1'b1;
        burst_data_i = 64'h1111_1111_1111_1111;
        tick();
        burst_data_i = 64'h2222_2222_2222_2222;
        tick();
        check("abort_partial", line_data_o[2*BEAT_W-1:0], {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        rst          = 1'b1;
        burst_resp_i = 1'b0;
        line_read_i  = 1'b0;
        tick();
        model_line = '0;
        check("abort_burst_read", burst_read_o, 1'b0);
        check("abort_line_data", line_data_o, '0);
        check("abort_no_resp", line_resp_o, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            burst_resp_i = 1'b1;
            burst_data_i = {$urandom(), $urandom()};
            tick();
            check("stray_line_data", line_data_o, '0);
            check("stray_burst_read", burst_read_o, 1'b0);
        end
        burst_resp_i = 1'b0;
        run_fill(mk(32'h0000_0040, 32'h0000_0040, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
                    64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004, 0, 1, 0, 0, 1'b0), 1);
        idle_after_fill();

`ifdef ICACHE_FILL_PERF_EN
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        model_line = '0;
        check("perf_reset_fill", fill_count_o, 32'd0);
        check("perf_reset_stall", stall_count_o, 32'd0);
        run_fill(mk(32'h0000_0100, 32'h0000_0100, 64'd1, 64'd2, 64'd3, 64'd4, 1, 2, 0, 2, 1'b0), 1);
        idle_after_fill();
        run_fill(mk(32'h0000_0200, 32'h0000_0200, 64'd5, 64'd6, 64'd7, 64'd8, 0, 0, 5, 0, 1'b0), 1);
        idle_after_fill();
        check("perf_fill_count", fill_count_o, 32'd2);
        check("perf_stall_count", stall_count_o, 32'd10);
`endif

        tick();
        check("resp_count", resp_seen, fills_pushed);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
